alu_frame_responder: RTL and testbench

Host-side responder for the ALU tapeout: receives a 3-byte command frame (opcode, operand A, operand B) over a valid/ready byte stream and executes the operation in a registered ALU. It returns the 8-bit result plus flags over a valid/ack handshake. It sits between the top-level pin wrapper (host drives ui_in/uio_in, reads uo_out) and the arithmetic core. The top wrapper inverts rst_n to drive rst.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_core.sv | 39 +++
 rtl/alu_frame_responder.sv | 79 +++++++
 tb/tb_alu_frame_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag index and FSM state definitions shared by the ALU responder
package alu_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP} op_e;
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} state_e;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 8-bit ALU producing result and {V,N,C,Z} flags
module alu_core
    import alu_pkg::*;
(
    input  op_e        op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic [3:0] flags
);
    logic [8:0] sum, diff, shl, shr;
    logic       c, v, sub_v;
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign sub_v = (a[7] != b[7]) && (diff[7] != a[7]);
    // The extra bit catches the last bit shifted out; a zero shift leaves it 0
    assign shl   = {1'b0, a} << b[2:0];
    assign shr   = {a, 1'b0} >> b[2:0];
    always_comb begin
        result = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin result = sum[7:0]; c = sum[8]; v = (a[7] == b[7]) && (sum[7] != a[7]); end
            OP_SUB: begin result = diff[7:0]; c = diff[8]; v = sub_v; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: {c, result} = shl;
            OP_SHR: {result, c} = shr;
            OP_CMP: begin c = diff[8]; v = sub_v; end
        endcase
        flags = '0;
        flags[FLAG_Z] = (op == OP_CMP) ? (a == b) : (result == 8'd0);
        flags[FLAG_N] = (op == OP_CMP) ? diff[7] : result[7];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_frame_responder.sv
// alu_frame_responder: receives opcode/A/B byte frames, executes them on alu_core and returns result+flags
module alu_frame_responder
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic [3:0] out_flags,
    output logic       out_valid,
    input  logic       out_ack,
    output logic       busy,
    output logic       err
);
    state_e          state;
    op_e             op;
    logic [7:0]      a, b, res;
    logic [3:0]      flg;
    logic [TO_W-1:0] cnt;
    logic            xfer;
    assign in_ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
    assign busy     = state != IDLE;
    assign xfer     = in_valid && in_ready;
    alu_core u_core (.op(op), .a(a), .b(b), .result(res), .flags(flg));
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_ADD;
            a         <= '0;
            b         <= '0;
            out_data  <= '0;
            out_flags <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    if (in_data[7:3] == 5'd0) begin
                        op    <= op_e'(in_data[2:0]);
                        state <= GET_A;
                    end else err <= 1'b1;
                end
                GET_A, GET_B: if (xfer) begin
                    cnt <= '0;
                    if (state == GET_A) begin
                        a     <= in_data;
                        state <= GET_B;
                    end else begin
                        b     <= in_data;
                        state <= EXEC;
                    end
                end else if (TIMEOUT != 0 && cnt == TO_W'(TIMEOUT - 1)) begin
                    // Abandon the partial frame; out_data keeps the last result
                    cnt   <= '0;
                    err   <= 1'b1;
                    state <= IDLE;
                end else if (TIMEOUT != 0) cnt <= cnt + 1'b1;
                EXEC: begin
                    out_data  <= res;
                    out_flags <= flg;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (out_ack) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_frame_responder.sv
// tb_alu_frame_responder: directed frame tests with hand-computed results for alu_frame_responder
module tb_alu_frame_responder;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ack = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, busy, err;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    int checks = 0, errors = 0;
    alu_frame_responder dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid), .out_ack(out_ack),
        .busy(busy), .err(err)
    );
    always #5 clk = ~clk;
    // Inputs change and outputs are sampled on the falling edge
    task automatic send(input logic [7:0] d);
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic frame(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
        send(o);
        send(x);
        send(y);
    endtask
    task automatic ack();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, err, out_data, out_flags} !== {4'b1000, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL reset rdy/vld/busy/err/data/flags got %b %b %b %b %h %h exp 1 0 0 0 00 0",
                     in_ready, out_valid, busy, err, out_data, out_flags);
        end
        rst = 1'b0;
    endtask
    task automatic test_add();
        frame(8'h00, 8'hF0, 8'h20);
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL add_exec vld/rdy/busy got %b%b%b exp 001", out_valid, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h10, 4'b0010}) begin
            errors++;
            $display("FAIL add_result vld/data/flags got %b %h %b exp 1 10 0010", out_valid, out_data, out_flags);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_data, out_flags, in_ready} !== {1'b1, 8'h10, 4'b0010, 1'b0}) begin
                errors++;
                $display("FAIL add_hold[%0d] vld/data/flags/rdy got %b %h %b %b exp 1 10 0010 0",
                         i, out_valid, out_data, out_flags, in_ready);
            end
        end
        ack();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL add_ack vld/busy/rdy got %b%b%b exp 001", out_valid, busy, in_ready);
        end
    endtask
    task automatic test_sub_cmp();
        frame(8'h01, 8'h80, 8'h01);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h7F, 4'b1000}) begin
            errors++;
            $display("FAIL sub vld/data/flags got %b %h %b exp 1 7f 1000", out_valid, out_data, out_flags);
        end
        ack();
        frame(8'h07, 8'h05, 8'h05);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h00, 4'b0001}) begin
            errors++;
            $display("FAIL cmp vld/data/flags got %b %h %b exp 1 00 0001", out_valid, out_data, out_flags);
        end
        ack();
    endtask
    task automatic test_shift();
        frame(8'h05, 8'h81, 8'h01);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h02, 4'b0010}) begin
            errors++;
            $display("FAIL shl vld/data/flags got %b %h %b exp 1 02 0010", out_valid, out_data, out_flags);
        end
        ack();
        frame(8'h06, 8'h01, 8'h00);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h01, 4'b0000}) begin
            errors++;
            $display("FAIL shr vld/data/flags got %b %h %b exp 1 01 0000", out_valid, out_data, out_flags);
        end
        ack();
    endtask
    task automatic test_back_to_back();
        frame(8'h00, 8'h7F, 8'h01);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h80, 4'b1100}) begin
            errors++;
            $display("FAIL b2b_add vld/data/flags got %b %h %b exp 1 80 1100", out_valid, out_data, out_flags);
        end
        ack();
        frame(8'h03, 8'h00, 8'h00);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h00, 4'b0001}) begin
            errors++;
            $display("FAIL b2b_or vld/data/flags got %b %h %b exp 1 00 0001", out_valid, out_data, out_flags);
        end
        ack();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        checks++;
        if ({out_valid, busy, out_data} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL stray_ack vld/busy/data got %b %b %h exp 0 0 00", out_valid, busy, out_data);
        end
    endtask
    task automatic test_bad_opcode();
        send(8'h08);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL badop err/busy got %b%b exp 10", err, busy);
        end
        @(negedge clk);
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL badop_pulse err/busy got %b%b exp 00", err, busy);
        end
        frame(8'h04, 8'hFF, 8'h0F);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'hF0, 4'b0100}) begin
            errors++;
            $display("FAIL xor vld/data/flags got %b %h %b exp 1 f0 0100", out_valid, out_data, out_flags);
        end
        ack();
    endtask
    task automatic test_timeout();
        bit seen = 1'b0;
        send(8'h00);
        send(8'h11);
        repeat (250) @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early busy/err got %b%b exp 10", busy, err);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = err;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_err got err=0 exp err pulse within budget");
        end
        checks++;
        if ({busy, out_valid, out_data} !== {2'b00, 8'hF0}) begin
            errors++;
            $display("FAIL timeout_state busy/vld/data got %b %b %h exp 0 0 f0", busy, out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse err got %b exp 0", err);
        end
    endtask
    task automatic test_resp_ignore();
        frame(8'h02, 8'hF0, 8'h3C);
        @(negedge clk);
        in_data = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, out_valid, out_data, out_flags} !== {2'b01, 8'h30, 4'b0000}) begin
                errors++;
                $display("FAIL resp_ignore[%0d] rdy/vld/data/flags got %b %b %h %b exp 0 1 30 0000",
                         i, in_ready, out_valid, out_data, out_flags);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        ack();
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL resp_noqueue busy/vld got %b%b exp 00", busy, out_valid);
        end
        frame(8'h03, 8'h0F, 8'hF0);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'hFF, 4'b0100}) begin
            errors++;
            $display("FAIL or vld/data/flags got %b %h %b exp 1 ff 0100", out_valid, out_data, out_flags);
        end
        ack();
    endtask
    task automatic test_reset_mid();
        send(8'h00);
        send(8'h11);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, err, out_data, out_flags} !== {4'b1000, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL rst_getb rdy/vld/busy/err/data/flags got %b %b %b %b %h %h exp 1 0 0 0 00 0",
                     in_ready, out_valid, busy, err, out_data, out_flags);
        end
        rst = 1'b0;
        frame(8'h01, 8'h05, 8'h07);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'hFE, 4'b0110}) begin
            errors++;
            $display("FAIL sub_borrow vld/data/flags got %b %h %b exp 1 fe 0110", out_valid, out_data, out_flags);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, err, out_data, out_flags} !== {4'b1000, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL rst_resp rdy/vld/busy/err/data/flags got %b %b %b %b %h %h exp 1 0 0 0 00 0",
                     in_ready, out_valid, busy, err, out_data, out_flags);
        end
        rst = 1'b0;
        frame(8'h00, 8'hF0, 8'h20);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_flags} !== {1'b1, 8'h10, 4'b0010}) begin
            errors++;
            $display("FAIL post_rst_add vld/data/flags got %b %h %b exp 1 10 0010", out_valid, out_data, out_flags);
        end
        ack();
    endtask
    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_cmp();
        test_shift();
        test_back_to_back();
        test_bad_opcode();
        test_timeout();
        test_resp_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
